// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - play-area geometry, direction codes and scheduler state encoding
package game_pkg;

    localparam int X_MIN    = 62;
    localparam int X_MAX    = 962;
    localparam int Y_MIN    = 108;
    localparam int Y_MAX    = 708;
    localparam int SIDE     = 60;
    localparam int TILE     = 60;
    localparam int MAP_COLS = 15;
    localparam int MAP_ROWS = (Y_MAX - Y_MIN) / TILE;
    localparam int ADDR_W   = 8;

    // 12-bit hero coordinates are widened by one bit so that x-1 / y-1 at
    // zero become negative instead of wrapping into the play area.
    localparam int COORD_W  = 12;
    localparam int ARITH_W  = 13;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        UP    = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Position of a (hero, direction) flag inside the collision vector.
    function automatic logic [2:0] coll_index(input logic hero, input logic [1:0] dir);
        return {hero, dir};
    endfunction

endpackage

// File: rtl/probe_addr_gen.sv
// rtl/probe_addr_gen.sv - corner probe point to map ROM address, with play-area bound check
module probe_addr_gen
    import game_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  dir_t               dir,
    input  logic               corner,
    output logic [ADDR_W-1:0]  map_addr,
    output logic               out_of_area
);

    localparam logic signed [ARITH_W-1:0] ONE_S     = ARITH_W'(1);
    localparam logic signed [ARITH_W-1:0] SIDE_S    = ARITH_W'(SIDE);
    localparam logic signed [ARITH_W-1:0] SIDE_M1_S = ARITH_W'(SIDE - 1);
    localparam logic signed [ARITH_W-1:0] X_MIN_S   = ARITH_W'(X_MIN);
    localparam logic signed [ARITH_W-1:0] X_MAX_S   = ARITH_W'(X_MAX);
    localparam logic signed [ARITH_W-1:0] Y_MIN_S   = ARITH_W'(Y_MIN);
    localparam logic signed [ARITH_W-1:0] Y_MAX_S   = ARITH_W'(Y_MAX);

    logic signed [ARITH_W-1:0] xs;
    logic signed [ARITH_W-1:0] ys;
    logic signed [ARITH_W-1:0] corner_off;
    logic signed [ARITH_W-1:0] px;
    logic signed [ARITH_W-1:0] py;
    logic signed [ARITH_W-1:0] dx;
    logic signed [ARITH_W-1:0] dy;
    logic [3:0]                col;
    logic [3:0]                row;

    // Probe point just outside the hero square on the requested side.
    always_comb begin
        xs         = signed'({1'b0, x});
        ys         = signed'({1'b0, y});
        corner_off = corner ? SIDE_M1_S : '0;
        px         = xs;
        py         = ys;
        case (dir)
            LEFT: begin
                px = xs - ONE_S;
                py = ys + corner_off;
            end
            RIGHT: begin
                px = xs + SIDE_S;
                py = ys + corner_off;
            end
            DOWN: begin
                px = xs + corner_off;
                py = ys + SIDE_S;
            end
            UP: begin
                px = xs + corner_off;
                py = ys - ONE_S;
            end
            default: begin
                px = xs;
                py = ys;
            end
        endcase
    end

    // Tile column/row by comparing against fixed tile boundaries instead of dividing.
    always_comb begin
        dx  = px - X_MIN_S;
        dy  = py - Y_MIN_S;
        col = '0;
        row = '0;
        for (int i = 1; i < MAP_COLS; i++) begin
            if (dx >= signed'(ARITH_W'(i * TILE))) col = 4'(i);
        end
        for (int j = 1; j < MAP_ROWS; j++) begin
            if (dy >= signed'(ARITH_W'(j * TILE))) row = 4'(j);
        end
        out_of_area = (px < X_MIN_S) || (px >= X_MAX_S) ||
                      (py < Y_MIN_S) || (py >= Y_MAX_S);
        map_addr    = ADDR_W'(row) * ADDR_W'(MAP_COLS) + ADDR_W'(col);
    end

endmodule

// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - time-shares the wall-map ROM across 16 corner probes per scan
module collision_scheduler
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [23:0]       x_pos,
    input  logic [23:0]       y_pos,
    output logic [ADDR_W-1:0] map_addr,
    output logic              map_en,
    input  logic              map_data,
    output logic [7:0]        collision,
    output logic              busy,
    output logic              done
);

    sched_state_t       state;
    logic [23:0]        x_snap;
    logic [23:0]        y_snap;
    logic [3:0]         p;
    logic [7:0]         shadow;
    logic [7:0]         shadow_next;

    // Slot whose address is currently on map_addr.
    logic               s1_valid;
    logic               s1_oob;
    logic               s1_last;
    logic [2:0]         s1_idx;

    // Slot whose ROM data is currently on map_data.
    logic               s2_valid;
    logic               s2_oob;
    logic               s2_en;
    logic               s2_last;
    logic [2:0]         s2_idx;

    logic               probe_hero;
    dir_t               probe_dir;
    logic               probe_corner;
    logic [COORD_W-1:0] probe_x;
    logic [COORD_W-1:0] probe_y;
    logic [ADDR_W-1:0]  gen_addr;
    logic               gen_oob;
    logic               hit;

    assign probe_hero   = p[3];
    assign probe_dir    = dir_t'(p[2:1]);
    assign probe_corner = p[0];
    assign probe_x      = probe_hero ? x_snap[23:12] : x_snap[11:0];
    assign probe_y      = probe_hero ? y_snap[23:12] : y_snap[11:0];

    probe_addr_gen u_probe_addr_gen (
        .x           (probe_x),
        .y           (probe_y),
        .dir         (probe_dir),
        .corner      (probe_corner),
        .map_addr    (gen_addr),
        .out_of_area (gen_oob)
    );

    // Fold the slot returning this cycle into the accumulator; skipped slots are blocked.
    always_comb begin
        hit         = s2_valid & (s2_oob | (s2_en & map_data));
        shadow_next = shadow;
        if (hit) shadow_next[s2_idx] = 1'b1;
    end

    // Scan sequencer: snapshot, issue 16 probes, drain the ROM pipeline, publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x_snap    <= '0;
            y_snap    <= '0;
            p         <= '0;
            shadow    <= '0;
            map_addr  <= '0;
            map_en    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_oob    <= 1'b0;
            s1_last   <= 1'b0;
            s1_idx    <= '0;
            s2_valid  <= 1'b0;
            s2_oob    <= 1'b0;
            s2_en     <= 1'b0;
            s2_last   <= 1'b0;
            s2_idx    <= '0;
            collision <= 8'hFF;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            map_en   <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= s1_valid;
            s2_oob   <= s1_oob;
            s2_en    <= map_en;
            s2_last  <= s1_last;
            s2_idx   <= s1_idx;
            shadow   <= shadow_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= PROBE;
                        x_snap <= x_pos;
                        y_snap <= y_pos;
                        shadow <= '0;
                        p      <= '0;
                        busy   <= 1'b1;
                    end
                end
                PROBE: begin
                    map_addr <= gen_addr;
                    map_en   <= ~gen_oob;
                    s1_valid <= 1'b1;
                    s1_oob   <= gen_oob;
                    s1_idx   <= coll_index(probe_hero, probe_dir);
                    s1_last  <= (p == 4'd15);
                    p        <= p + 4'd1;
                    if (p == 4'd15) state <= DRAIN;
                end
                DRAIN: begin
                    if (s2_valid && s2_last) begin
                        collision <= shadow_next;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scheduler.sv
// tb/tb_collision_scheduler.sv - self-checking bench for collision_scheduler
module tb_collision_scheduler;

    localparam int X_MIN    = 62;
    localparam int X_MAX    = 962;
    localparam int Y_MIN    = 108;
    localparam int Y_MAX    = 708;
    localparam int SIDE     = 60;
    localparam int TILE     = 60;
    localparam int MAP_COLS = 15;
    localparam int LATENCY  = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] x_pos = '0;
    logic [23:0] y_pos = '0;
    logic [7:0]  map_addr;
    logic        map_en;
    logic        map_data = 1'b0;
    logic [7:0]  collision;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int en_count = 0;
    bit checking = 0;

    bit rom [0:255];

    bit       m_busy = 0;
    bit       m_done = 0;
    bit [7:0] m_coll = 8'hFF;
    bit [7:0] m_res = 8'h00;
    int       m_cnt = 0;
    bit       exp_en [0:15];
    bit [7:0] exp_addr [0:15];

    collision_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .map_addr  (map_addr),
        .map_en    (map_en),
        .map_data  (map_data),
        .collision (collision),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // ROM: data one cycle after enable, noise when not enabled
    always @(posedge clk) map_data <= map_en ? rom[map_addr] : 1'($urandom);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk the 16 probe points geometrically and derive the scan outcome.
    function automatic void build_expect(input logic [23:0] xp, input logic [23:0] yp);
        m_res = 8'h00;
        for (int h = 0; h < 2; h++) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 2; c++) begin
                    int x, y, px, py, k;
                    bit in_area;
                    x = (h == 1) ? int'(xp[23:12]) : int'(xp[11:0]);
                    y = (h == 1) ? int'(yp[23:12]) : int'(yp[11:0]);
                    case (d)
                        0:       begin px = x - 1;              py = y + c * (SIDE - 1); end
                        1:       begin px = x + SIDE;           py = y + c * (SIDE - 1); end
                        2:       begin px = x + c * (SIDE - 1); py = y + SIDE;           end
                        default: begin px = x + c * (SIDE - 1); py = y - 1;              end
                    endcase
                    in_area = (px >= X_MIN) && (px < X_MAX) && (py >= Y_MIN) && (py < Y_MAX);
                    k = h * 8 + d * 2 + c;
                    exp_en[k]   = in_area;
                    exp_addr[k] = in_area ? 8'(((py - Y_MIN) / TILE) * MAP_COLS + (px - X_MIN) / TILE) : 8'd0;
                    if (!in_area || rom[exp_addr[k]]) m_res[h * 4 + d] = 1'b1;
                end
            end
        end
    endfunction

    // Reference timing: accept start only when idle, publish a fixed number of cycles later
    always @(posedge clk) begin
        bit was_done;
        was_done = m_done;
        m_done = 0;
        if (rst) begin
            m_busy = 0;
            m_coll = 8'hFF;
            m_cnt  = 0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == LATENCY) begin
                m_busy = 0;
                m_done = 1;
                m_coll = m_res;
            end
        end else if (start && !was_done) begin
            m_busy = 1;
            m_cnt  = 0;
            build_expect(x_pos, y_pos);
        end
    end

    // Per-cycle comparison of every output against the reference
    always @(negedge clk) begin
        if (checking) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("collision", collision, m_coll);
            if (m_busy && m_cnt >= 1 && m_cnt <= 16) begin
                check("map_en", map_en, exp_en[m_cnt - 1]);
                if (exp_en[m_cnt - 1] && map_en) check("map_addr", map_addr, exp_addr[m_cnt - 1]);
            end else begin
                check("map_en_idle", map_en, 0);
            end
        end
        if (map_en) en_count++;
    end

    task automatic scan(input logic [23:0] xp, input logic [23:0] yp, input int chg_cyc,
                        input int st_a, input int st_b, input int rst_cyc,
                        output logic [7:0] coll, output int cyc, output bit got_done);
        x_pos    = xp;
        y_pos    = yp;
        start    = 1'b1;
        en_count = 0;
        got_done = 0;
        @(negedge clk);
        for (cyc = 0; cyc < 40; cyc++) begin
            start = (cyc == st_a) || (cyc == st_b);
            rst   = (cyc == rst_cyc);
            if (cyc == chg_cyc) begin
                x_pos = 24'($urandom);
                y_pos = 24'($urandom);
            end
            if (done) begin
                got_done = 1;
                break;
            end
            @(negedge clk);
        end
        coll = collision;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
    endtask

    function automatic logic [11:0] rand_x();
        if ($urandom_range(0, 7) == 0) return 12'($urandom);
        return 12'($urandom_range(0, 1000));
    endfunction

    function automatic logic [11:0] rand_y();
        if ($urandom_range(0, 7) == 0) return 12'($urandom);
        return 12'($urandom_range(50, 760));
    endfunction

    initial begin
        logic [7:0]  coll;
        logic [23:0] hx;
        logic [23:0] hy;
        int          cyc;
        bit          got;

        for (int a = 0; a < 256; a++) rom[a] = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_collision", collision, 8'hFF);
        check("reset_map_addr", map_addr, 8'h00);
        check("reset_map_en", map_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        checking = 1;
        rst = 1'b0;
        @(negedge clk);

        hx = {12'd422, 12'd542};
        hy = {12'd648, 12'd648};

        scan(hx, hy, -1, -1, -1, -1, coll, cyc, got);
        check("empty_done", got, 1);
        check("empty_latency", cyc, LATENCY);
        check("empty_coll", coll, 8'h44);
        check("empty_en_count", en_count, 12);

        rom[142] = 1;
        scan(hx, hy, -1, -1, -1, -1, coll, cyc, got);
        check("wall142_latency", cyc, LATENCY);
        check("wall142_coll", coll, 8'h65);

        for (int a = 0; a < 256; a++) rom[a] = 1;
        scan(hx, hy, -1, -1, -1, -1, coll, cyc, got);
        check("full_coll", coll, 8'hFF);
        check("full_en_count", en_count, 12);

        for (int a = 0; a < 256; a++) rom[a] = 0;
        scan({12'd62, 12'd62}, {12'd108, 12'd108}, -1, -1, -1, -1, coll, cyc, got);
        check("corner_coll", coll, 8'h99);
        check("corner_en_count", en_count, 8);

        scan({12'd902, 12'd902}, {12'd648, 12'd648}, -1, -1, -1, -1, coll, cyc, got);
        check("far_edge_coll", coll, 8'h66);

        rom[142] = 1;
        scan(hx, hy, 3, 5, 18, -1, coll, cyc, got);
        check("ignore_latency", cyc, LATENCY);
        check("ignore_coll", coll, 8'h65);
        repeat (3) @(negedge clk);
        check("ignore_no_restart", busy, 0);

        scan(hx, hy, -1, -1, -1, 10, coll, cyc, got);
        check("abort_no_done", got, 0);
        check("abort_coll", coll, 8'hFF);
        scan(hx, hy, -1, -1, -1, -1, coll, cyc, got);
        check("after_abort_latency", cyc, LATENCY);
        check("after_abort_coll", coll, 8'h65);

        for (int it = 0; it < 60; it++) begin
            bit do_rst;
            int chg, sa, rc;
            for (int a = 0; a < 256; a++) rom[a] = ($urandom_range(0, 3) == 0);
            do_rst = ($urandom_range(0, 9) == 0);
            chg    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 17)) : -1;
            sa     = do_rst ? -1 : int'($urandom_range(1, 18));
            rc     = do_rst ? int'($urandom_range(1, 17)) : -1;
            scan({rand_x(), rand_x()}, {rand_y(), rand_y()}, chg, sa, -1, rc, coll, cyc, got);
            if (do_rst) begin
                check("rand_abort", got, 0);
            end else begin
                check("rand_done", got, 1);
                check("rand_latency", cyc, LATENCY);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
